// File: rtl/alu_issue_ctrl_pkg.sv
// Shared definitions for the ALU issue controller: instruction format, opcodes, FSM states.
package alu_issue_ctrl_pkg;

    localparam int unsigned ALU_RESULT_W = 32;
    localparam int unsigned OPERAND_W    = 32;
    localparam int unsigned OPCODE_W     = 4;

    // Opcode field is wider than the defined set so unknown encodings can reach the ALU.
    typedef enum logic [OPCODE_W-1:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_MUL = 4'd2,
        OP_AND = 4'd3,
        OP_OR  = 4'd4,
        OP_XOR = 4'd5,
        OP_SHL = 4'd6,
        OP_SHR = 4'd7
    } opcode_t;

    typedef struct packed {
        opcode_t               opcode;
        logic [OPERAND_W-1:0]  a;
        logic [OPERAND_W-1:0]  b;
    } instruction_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } alu_ctrl_state_t;

    // MUL is the only opcode routed through the multicycle path.
    function automatic logic is_multicycle(input opcode_t op);
        return op == OP_MUL;
    endfunction

endpackage

// File: rtl/alu_issue_ctrl_rr_arbiter.sv
// Reusable round-robin arbiter: first requester at or after ptr wins (combinational).
module alu_issue_ctrl_rr_arbiter #(
    parameter  int unsigned N  = 2,
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          valid
);

    int unsigned   cand;
    logic [IW-1:0] cand_idx;

    // Scan requesters starting at ptr, wrapping modulo N; keep the first hit.
    always_comb begin
        grant    = '0;
        idx      = '0;
        valid    = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int unsigned k = 0; k < N; k++) begin
            cand = 32'(ptr) + k;
            if (cand >= N) begin
                cand = cand - N;
            end
            cand_idx = IW'(cand);
            if (!valid && req[cand_idx]) begin
                valid           = 1'b1;
                grant[cand_idx] = 1'b1;
                idx             = cand_idx;
            end
        end
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issues one requester's instruction at a time to a shared external ALU and returns the result.
module alu_issue_ctrl
    import alu_issue_ctrl_pkg::*;
#(
    parameter  int unsigned NUM_REQ    = 2,
    parameter  int unsigned MUL_CYCLES = 4,
    localparam int unsigned ID_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  instruction_t            req_iw [NUM_REQ],
    output instruction_t            alu_iw,
    input  logic [ALU_RESULT_W-1:0] alu_result,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [ALU_RESULT_W-1:0] rsp_result,
    output logic [ID_W-1:0]         rsp_id,
    output logic                    busy
);

    localparam int unsigned CNT_W = 4;

    alu_ctrl_state_t  state;
    logic [ID_W-1:0]  rr_ptr;
    logic [ID_W-1:0]  id;
    logic [CNT_W-1:0] cnt;

    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    grant_idx;
    logic               grant_valid;
    logic [ID_W-1:0]    next_ptr;
    instruction_t       win_iw;

    alu_issue_ctrl_rr_arbiter #(
        .N (NUM_REQ)
    ) u_rr_arbiter (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .grant (grant),
        .idx   (grant_idx),
        .valid (grant_valid)
    );

    assign win_iw   = req_iw[grant_idx];
    assign next_ptr = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + ID_W'(1);

    // Accept strobe is only offered while idle and out of reset.
    assign req_ready = ((state == IDLE) && rst_n) ? grant : '0;

    // Controller FSM with instruction/id/result registers and the MUL wait counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            id         <= '0;
            cnt        <= '0;
            alu_iw     <= '0;
            rsp_valid  <= 1'b0;
            rsp_result <= '0;
            rsp_id     <= '0;
            busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        alu_iw <= win_iw;
                        id     <= grant_idx;
                        rr_ptr <= next_ptr;
                        cnt    <= is_multicycle(win_iw.opcode) ? CNT_W'(MUL_CYCLES - 1) : '0;
                        busy   <= 1'b1;
                        state  <= EXEC;
                    end
                end
                EXEC: begin
                    if (cnt == '0) begin
                        rsp_result <= alu_result;
                        rsp_id     <= id;
                        rsp_valid  <= 1'b1;
                        state      <= RESP;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
